servo_pwm_decoder: RTL and testbench

Measures the high time of an incoming hobby-servo PWM frame and recovers the 8-bit servo command byte, i.e. the inverse of the `pwm_servo` encoding.
- Output format: bit 7 = direction (1 forward / 0 reverse), bits 6:0 = angle 0..90.
- Used for loop-back checking of the servo generator and for reading commands from an external RC receiver on the board's 12 MHz clock.

---
 rtl/servo_pwm_decoder.sv | 170 +++++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures the high time of a hobby-servo PWM frame in
// microseconds and recovers the command byte {direction, angle 0..90}.
// Also flags out-of-range pulses (err) and loss of the PWM signal (lost).
module servo_pwm_decoder #(
    parameter logic [23:0] CLK_FRE        = 24'd12_000_000,
    parameter logic [4:0]  PWM_CYCLE_TIME = 5'd20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    output logic [7:0] cfg,
    output logic       cfg_valid,
    output logic       err,
    output logic       lost
);

    localparam int TICK_DIV = int'(CLK_FRE) / 1_000_000;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
    localparam int LOSS_US  = 2 * int'(PWM_CYCLE_TIME) * 1000;
    localparam logic [15:0] LOSS_MAX = 16'(LOSS_US);

    typedef enum logic [1:0] {IDLE, HIGH, WAIT_LOW, CALC} state_t;

    state_t         state_q, state_d;
    logic [2:0]     sync_q;
    logic [PW-1:0]  presc_q, presc_d;
    logic [11:0]    w_q, w_d, w_now;
    logic [13:0]    n_q, n_d, n_c;
    logic [10:0]    d_c;
    logic           dir_c;
    logic [6:0]     q_q, q_d;
    logic           dir_q, dir_d;
    logic [7:0]     cfg_q, cfg_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic [15:0]    loss_q, loss_d;
    logic           lost_q, lost_d;
    logic           rise, fall, us_tick;

    // Synchronizer resets high so a pulse already in progress at reset
    // release does not look like a rising edge and is never measured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 3'b111;
        else        sync_q <= {sync_q[1:0], pwm_in};
    end

    assign rise    = sync_q[1] & ~sync_q[2];
    assign fall    = ~sync_q[1] & sync_q[2];
    assign us_tick = (presc_q == TICK_MAX);

    // Width including the tick of the current cycle, so w = floor(H/TICK_DIV).
    assign w_now = w_q + {11'd0, us_tick};

    // Microsecond prescaler, re-phased on every rising edge.
    always_comb begin
        presc_d = presc_q + 1'b1;
        if (rise || us_tick) presc_d = '0;
    end

    // Decode arithmetic on the width as it stands this cycle.
    always_comb begin
        dir_c = (w_now >= 12'd1500);
        d_c   = dir_c ? 11'(w_now - 12'd1500) : 11'(12'd1500 - w_now);
        n_c   = ({3'b000, d_c} << 3) + {3'b000, d_c};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (rise) state_d = HIGH;
            HIGH: begin
                if (w_now >= 12'd2501)  state_d = fall ? IDLE : WAIT_LOW;
                else if (fall)          state_d = (w_now < 12'd500) ? IDLE : CALC;
            end
            WAIT_LOW: if (fall) state_d = IDLE;
            CALC:     if (n_q < 14'd100) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs and datapath next values (width, divider, command).
    always_comb begin
        w_d     = w_q;
        n_d     = n_q;
        q_d     = q_q;
        dir_d   = dir_q;
        cfg_d   = cfg_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (rise) w_d = 12'd0;
            HIGH: begin
                w_d = w_now;
                if (w_now >= 12'd2501) begin
                    err_d = 1'b1;
                end else if (fall) begin
                    if (w_now < 12'd500) begin
                        err_d = 1'b1;
                    end else begin
                        dir_d = dir_c;
                        n_d   = n_c;
                        q_d   = 7'd0;
                    end
                end
            end
            CALC: begin
                // Restoring division by 100, one subtraction per clock.
                if (n_q >= 14'd100) begin
                    n_d = n_q - 14'd100;
                    q_d = q_q + 7'd1;
                end else begin
                    cfg_d   = {dir_q, q_q};
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Signal-loss timer: counts microseconds since the last rise, saturating.
    always_comb begin
        loss_d = loss_q;
        if (rise)                             loss_d = 16'd0;
        else if (us_tick && loss_q != LOSS_MAX) loss_d = loss_q + 16'd1;
        lost_d = lost_q;
        if (valid_d)                  lost_d = 1'b0;
        else if (loss_d == LOSS_MAX)  lost_d = 1'b1;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            w_q     <= 12'd0;
            n_q     <= 14'd0;
            q_q     <= 7'd0;
            dir_q   <= 1'b0;
            cfg_q   <= 8'h80;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            loss_q  <= 16'd0;
            lost_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            w_q     <= w_d;
            n_q     <= n_d;
            q_q     <= q_d;
            dir_q   <= dir_d;
            cfg_q   <= cfg_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            loss_q  <= loss_d;
            lost_q  <= lost_d;
        end
    end

    assign cfg       = cfg_q;
    assign cfg_valid = valid_q;
    assign err       = err_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder. Runs at 2 clocks per microsecond and
// a 2 ms nominal period (4 ms loss timeout) to keep the run short.
module tb_servo_pwm_decoder;

    localparam int T        = 2;      // clocks per microsecond
    localparam int GAP      = 300;    // low clocks after each pulse
    localparam int LOSS_CLK = 4000 * T;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] cfg;
    logic       cfg_valid;
    logic       err;
    logic       lost;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int last_rise = 0;
    logic [7:0] model_cfg = 8'h80;
    logic       model_lost = 1'b0;
    logic [7:0] exp_q[$];

    servo_pwm_decoder #(
        .CLK_FRE        (24'd2_000_000),
        .PWM_CYCLE_TIME (5'd2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .cfg       (cfg),
        .cfg_valid (cfg_valid),
        .err       (err),
        .lost      (lost)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model(input int us);
        int d;
        logic dir;
        dir = (us >= 1500);
        d   = dir ? us - 1500 : 1500 - us;
        return {dir, 7'((d * 9) / 100)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks; at each falling edge pop/compare the scoreboard.
    task automatic step(input int n);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (err === 1'b1) err_cnt++;
            if (err === 1'b1 || cfg_valid === 1'b1)
                chk("err_valid_exclusive", 32'(err & cfg_valid), 32'd0);
            if (cfg_valid === 1'b1) begin
                valid_cnt++;
                chk("valid_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("cfg_decode", 32'(cfg), 32'(e));
                end
            end
        end
    endtask

    // kind: 0 = valid frame, 1 = err at fall, 2 = err while still high.
    task automatic do_frame(input int us, input int kind);
        int e0, v0;
        e0 = err_cnt;
        v0 = valid_cnt;
        if (kind == 0) exp_q.push_back(model(us));
        pwm_in = 1'b1;
        last_rise = cyc;
        step(us * T);
        chk("err_while_high", 32'(err_cnt - e0), 32'(kind == 2));
        chk("lost_during_high", 32'(lost), 32'(model_lost));
        pwm_in = 1'b0;
        step(GAP);
        chk("err_count", 32'(err_cnt - e0), 32'(kind != 0));
        chk("valid_count", 32'(valid_cnt - v0), 32'(kind == 0));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        if (kind == 0) begin
            model_cfg  = model(us);
            model_lost = 1'b0;
        end
        chk("cfg_hold", 32'(cfg), 32'(model_cfg));
        chk("lost_after_frame", 32'(lost), 32'(model_lost));
        $display("frame %0d us kind %0d -> cfg=%02h lost=%0b", us, kind, cfg, lost);
    endtask

    initial begin
        int v0;
        step(3);
        chk("reset_cfg", 32'(cfg), 32'h80);
        chk("reset_valid", 32'(cfg_valid), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_lost", 32'(lost), 32'd0);
        rst_n = 1'b1;
        step(5);

        do_frame(1500, 0);
        do_frame(1500, 0);
        do_frame(2500, 0);
        do_frame(500,  0);
        do_frame(1501, 0);
        do_frame(1499, 0);
        do_frame(1000, 0);
        do_frame(2000, 0);
        do_frame(2600, 2);
        do_frame(400,  1);

        // Signal loss: no rise for longer than the timeout.
        do_frame(1500, 0);
        while (cyc < last_rise + LOSS_CLK + 1) step(1);
        chk("lost_before_timeout", 32'(lost), 32'd0);
        while (cyc < last_rise + LOSS_CLK + 4) step(1);
        chk("lost_at_timeout", 32'(lost), 32'd1);
        $display("loss timeout -> lost=%0b", lost);
        model_lost = 1'b1;
        step(1000);
        do_frame(1500, 0);

        // Reset in the middle of a 2000 us pulse.
        do_frame(1000, 0);
        v0 = valid_cnt;
        pwm_in = 1'b1;
        step(300 * T);
        rst_n = 1'b0;
        #1;
        chk("midreset_cfg", 32'(cfg), 32'h80);
        chk("midreset_valid", 32'(cfg_valid), 32'd0);
        chk("midreset_err", 32'(err), 32'd0);
        chk("midreset_lost", 32'(lost), 32'd0);
        step(4);
        rst_n = 1'b1;
        step(1700 * T - 4);
        pwm_in = 1'b0;
        step(GAP);
        model_cfg = 8'h80;
        chk("midreset_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("midreset_cfg_after", 32'(cfg), 32'h80);
        $display("reset mid-pulse -> cfg=%02h", cfg);
        do_frame(2000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
